// File: rtl/rx_frame_check.sv
// Checks SOF-delimited, fixed-length frames that carry an incrementing test pattern
// on the aligned GTX receive stream. Reports per-frame status, error counters and link lock.
module rx_frame_check #(
    parameter int FRAME_LEN  = 256,
    parameter int LOCK_GOOD  = 4,
    parameter int UNLOCK_BAD = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [31:0] rx_data_align,
    input  logic [3:0]  rx_ctrl_align,
    input  logic        clr_cnt,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] word_err_cnt,
    output logic [31:0] frame_cnt,
    output logic [15:0] bad_frame_cnt,
    output logic        link_locked
);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [15:0]       LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_GOOD);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(UNLOCK_BAD);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t            state;
    logic [15:0]       idx;
    logic              frame_bad;
    logic [GOOD_W-1:0] good_run;
    logic [BAD_W-1:0]  bad_run;
    logic [TO_W-1:0]   to_cnt;

    logic              is_sof;
    logic              is_data;
    logic              in_payload;
    logic              word_bad;
    logic              last_word;
    logic              done_ok;
    logic              done_err;
    logic              timed_out;
    logic [GOOD_W-1:0] good_nxt;
    logic [BAD_W-1:0]  bad_nxt;
    logic [TO_W-1:0]   to_nxt;

    assign is_sof     = (rx_ctrl_align == 4'b0001) && (rx_data_align[7:0] == 8'hFB);
    assign is_data    = (rx_ctrl_align == 4'b0000);
    assign in_payload = (state == PAYLOAD);

    // Inside a frame, IDLE and ILLEGAL words fail the pattern test exactly like a wrong value.
    assign word_bad  = in_payload && !is_sof && !(is_data && (rx_data_align == {16'h0000, idx}));
    assign last_word = in_payload && !is_sof && (idx == LAST_IDX);
    assign done_ok   = last_word && !frame_bad && !word_bad;
    assign done_err  = (last_word && (frame_bad || word_bad)) || (in_payload && is_sof);

    always_comb begin
        // NOTE: every combinational output is given a default first, so no latch can be inferred.
        good_nxt = good_run;
        bad_nxt  = bad_run;
        to_nxt   = to_cnt;
        if (done_ok) begin
            bad_nxt = '0;
            if (good_run != GOOD_MAX) good_nxt = good_run + 1'b1;
        end else if (done_err) begin
            good_nxt = '0;
            if (bad_run != BAD_MAX) bad_nxt = bad_run + 1'b1;
        end
        if (is_sof)                to_nxt = '0;
        else if (to_cnt != TO_MAX) to_nxt = to_cnt + 1'b1;
        timed_out = (to_nxt == TO_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            idx           <= '0;
            frame_bad     <= 1'b0;
            good_run      <= '0;
            bad_run       <= '0;
            to_cnt        <= '0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            word_err_cnt  <= '0;
            frame_cnt     <= '0;
            bad_frame_cnt <= '0;
            link_locked   <= 1'b0;
        end else begin
            frame_ok  <= done_ok;
            frame_err <= done_err;
            good_run  <= good_nxt;
            bad_run   <= bad_nxt;
            to_cnt    <= to_nxt;

            // Loss of lock has priority over acquiring it in the same cycle.
            if (timed_out || (done_err && bad_nxt == BAD_MAX))
                link_locked <= 1'b0;
            else if (done_ok && good_nxt == GOOD_MAX)
                link_locked <= 1'b1;

            if (clr_cnt) begin
                word_err_cnt  <= '0;
                frame_cnt     <= '0;
                bad_frame_cnt <= '0;
            end else begin
                if (word_bad && word_err_cnt != 16'hFFFF)  word_err_cnt  <= word_err_cnt + 16'd1;
                if (done_err && bad_frame_cnt != 16'hFFFF) bad_frame_cnt <= bad_frame_cnt + 16'd1;
                if (done_ok || done_err)                   frame_cnt     <= frame_cnt + 32'd1;
            end

            case (state)
                HUNT: begin
                    if (is_sof) begin
                        state     <= PAYLOAD;
                        idx       <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (is_sof) begin
                        idx       <= '0;
                        frame_bad <= 1'b0;
                    end else if (idx == LAST_IDX) begin
                        state <= HUNT;
                    end else begin
                        idx <= idx + 16'd1;
                        if (word_bad) frame_bad <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_frame_check.sv
// Self-checking bench for rx_frame_check: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based frame model.
module tb_rx_frame_check;
    localparam int FRAME_LEN  = 8;
    localparam int LOCK_GOOD  = 4;
    localparam int UNLOCK_BAD = 2;
    localparam int TIMEOUT    = 64;

    localparam logic [31:0] SOF_W  = 32'h0000_00FB;
    localparam logic [31:0] IDLE_W = 32'h0000_00BC;
    localparam logic [3:0]  K0     = 4'b0001;
    localparam logic [3:0]  DC     = 4'b0000;

    logic        rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rx_data_align = 32'h0;
    logic [3:0]  rx_ctrl_align = 4'h0;
    logic        clr_cnt = 1'b0;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] word_err_cnt;
    logic [31:0] frame_cnt;
    logic [15:0] bad_frame_cnt;
    logic        link_locked;

    always #5 rx_clk = ~rx_clk;

    rx_frame_check #(
        .FRAME_LEN(FRAME_LEN), .LOCK_GOOD(LOCK_GOOD),
        .UNLOCK_BAD(UNLOCK_BAD), .TIMEOUT(TIMEOUT)
    ) dut (
        .rx_clk(rx_clk), .rst(rst),
        .rx_data_align(rx_data_align), .rx_ctrl_align(rx_ctrl_align), .clr_cnt(clr_cnt),
        .frame_ok(frame_ok), .frame_err(frame_err),
        .word_err_cnt(word_err_cnt), .frame_cnt(frame_cnt),
        .bad_frame_cnt(bad_frame_cnt), .link_locked(link_locked)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the words of the open frame sit in a queue; its length is the index.
    int unsigned frame_q[$];
    bit          m_in_frame;
    int          m_frame_errs;
    int          m_werr, m_bad, m_good, m_bad_run;
    int unsigned m_fcnt;
    bit          m_ok, m_err, m_locked;
    int          m_cyc, m_last_sof;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        m_in_frame = 0; m_frame_errs = 0;
        m_werr = 0; m_bad = 0; m_fcnt = 0; m_good = 0; m_bad_run = 0;
        m_ok = 0; m_err = 0; m_locked = 0;
        m_cyc = 0; m_last_sof = 0;
    endtask

    task automatic model_step(input logic [31:0] d, input logic [3:0] c, input logic clr);
        bit sof;
        int werr_inc;
        sof = (c == 4'b0001) && (d[7:0] == 8'hFB);
        werr_inc = 0;
        m_ok = 0; m_err = 0;
        m_cyc++;
        if (sof) m_last_sof = m_cyc;
        if (m_in_frame) begin
            if (sof) begin
                m_err = 1;
                frame_q.delete();
                m_frame_errs = 0;
            end else begin
                if (!(c == 4'b0000 && d == 32'(frame_q.size()))) begin
                    m_frame_errs++;
                    werr_inc = 1;
                end
                frame_q.push_back(d);
                if (frame_q.size() == FRAME_LEN) begin
                    if (m_frame_errs == 0) m_ok = 1; else m_err = 1;
                    m_in_frame = 0;
                    frame_q.delete();
                end
            end
        end else if (sof) begin
            m_in_frame = 1;
            frame_q.delete();
            m_frame_errs = 0;
        end
        if (clr) begin
            m_werr = 0; m_bad = 0; m_fcnt = 0;
        end else begin
            m_werr = min_i(m_werr + werr_inc, 65535);
            m_bad  = min_i(m_bad + int'(m_err), 65535);
            m_fcnt = m_fcnt + ((m_ok || m_err) ? 1 : 0);
        end
        if (m_ok)  begin m_good = min_i(m_good + 1, LOCK_GOOD); m_bad_run = 0; end
        if (m_err) begin m_bad_run = min_i(m_bad_run + 1, UNLOCK_BAD); m_good = 0; end
        if ((m_cyc - m_last_sof) >= TIMEOUT || (m_err && m_bad_run >= UNLOCK_BAD))
            m_locked = 0;
        else if (m_ok && m_good >= LOCK_GOOD)
            m_locked = 1;
    endtask

    function automatic logic [95:0] dut_vec();
        return 96'({frame_ok, frame_err, link_locked, word_err_cnt, bad_frame_cnt, frame_cnt});
    endfunction

    function automatic logic [95:0] model_vec();
        return 96'({m_ok, m_err, m_locked, 16'(m_werr), 16'(m_bad), m_fcnt});
    endfunction

    always @(negedge rx_clk) begin
        if (cmp_en && !rst) check("outputs{ok,err,lock,werr,bad,fcnt}", dut_vec(), model_vec());
    end

    task automatic step(input logic [31:0] d, input logic [3:0] c, input logic clr);
        rx_data_align = d;
        rx_ctrl_align = c;
        clr_cnt       = clr;
        @(posedge rx_clk);
        #1 model_step(d, c, clr);
        @(negedge rx_clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE_W, K0, 1'b0);
    endtask

    task automatic send_payload(input int bad_idx, input logic [31:0] bad_val);
        for (int k = 0; k < FRAME_LEN; k++)
            step((k == bad_idx) ? bad_val : 32'(k), DC, 1'b0);
    endtask

    task automatic send_frame(input int bad_idx, input logic [31:0] bad_val);
        step(SOF_W, K0, 1'b0);
        send_payload(bad_idx, bad_val);
    endtask

    function automatic logic rclr();
        return ($urandom_range(0, 39) == 0);
    endfunction

    task automatic random_phase(input int n_frames);
        int          n_idle;
        logic [31:0] d;
        logic [3:0]  c;
        for (int f = 0; f < n_frames; f++) begin
            n_idle = $urandom_range(0, 3);
            for (int i = 0; i < n_idle; i++) begin
                case ($urandom_range(0, 3))
                    0:       step(32'h0, DC, rclr());
                    1:       step($urandom, 4'($urandom_range(2, 15)), rclr());
                    default: step(IDLE_W, K0, rclr());
                endcase
            end
            step(SOF_W, K0, rclr());
            for (int k = 0; k < FRAME_LEN; k++) begin
                d = 32'(k);
                c = DC;
                if ($urandom_range(0, 11) == 0) begin
                    case ($urandom_range(0, 3))
                        0: d = $urandom;
                        1: begin d = IDLE_W; c = K0; end
                        2: c = 4'($urandom_range(2, 15));
                        default: begin d = SOF_W; c = K0; end
                    endcase
                end
                step(d, c, rclr());
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge rx_clk);
        check("reset_outputs", dut_vec(), 96'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Five clean frames separated by two IDLE words; lock rises on the 4th frame_ok.
        send_idle(1);
        for (int f = 1; f <= 5; f++) begin
            send_frame(-1, 32'h0);
            check("t1_frame_ok", 96'(frame_ok), 96'd1);
            check("t1_lock", 96'(link_locked), (f >= 4) ? 96'd1 : 96'd0);
            send_idle(2);
            check("t1_pulse_width", 96'(frame_ok), 96'd0);
        end
        check("t1_frame_cnt", 96'(frame_cnt), 96'd5);
        check("t1_word_err", 96'(word_err_cnt), 96'd0);

        // Corrupted payload word 3: one bad frame keeps lock, the second drops it.
        send_frame(3, 32'hDEAD_BEEF);
        check("t2_frame_err", 96'(frame_err), 96'd1);
        check("t2_word_err", 96'(word_err_cnt), 96'd1);
        check("t2_bad_cnt", 96'(bad_frame_cnt), 96'd1);
        check("t2_lock_kept", 96'(link_locked), 96'd1);
        send_idle(2);
        send_frame(3, 32'hDEAD_BEEF);
        check("t2_lock_lost", 96'(link_locked), 96'd0);
        check("t2_bad_cnt2", 96'(bad_frame_cnt), 96'd2);
        send_idle(2);

        // SOF after payload word 4 truncates the frame; the restarted frame is clean.
        step(SOF_W, K0, 1'b0);
        for (int k = 0; k <= 4; k++) step(32'(k), DC, 1'b0);
        step(SOF_W, K0, 1'b0);
        check("t3_trunc_err", 96'(frame_err), 96'd1);
        send_payload(-1, 32'h0);
        check("t3_frame_ok", 96'(frame_ok), 96'd1);
        check("t3_frame_cnt", 96'(frame_cnt), 96'd9);
        check("t3_word_err", 96'(word_err_cnt), 96'd2);
        send_idle(2);

        // Relock, then starve SOFs: lock drops exactly TIMEOUT cycles after the last SOF.
        for (int f = 0; f < 4; f++) begin
            send_frame(-1, 32'h0);
            if (f < 3) send_idle(2);
        end
        check("t4_locked", 96'(link_locked), 96'd1);
        send_idle(TIMEOUT - FRAME_LEN - 1);
        check("t4_lock_before_to", 96'(link_locked), 96'd1);
        send_idle(1);
        check("t4_lock_after_to", 96'(link_locked), 96'd0);
        send_idle(3);
        check("t4_frame_cnt", 96'(frame_cnt), 96'd13);

        random_phase(80);
        send_idle(2);

        // Saturate word_err_cnt, then clear on a cycle that also carries a word error.
        step(IDLE_W, K0, 1'b1);
        check("t5_cleared", 96'(word_err_cnt), 96'd0);
        for (int f = 0; f < 8193; f++) begin
            step(SOF_W, K0, 1'b0);
            send_idle(FRAME_LEN);
        end
        check("t5_werr_sat", 96'(word_err_cnt), 96'hFFFF);
        check("t5_bad_cnt", 96'(bad_frame_cnt), 96'd8193);
        step(SOF_W, K0, 1'b0);
        step(IDLE_W, K0, 1'b1);
        check("t5_clr_counters", 96'({word_err_cnt, bad_frame_cnt, frame_cnt}), 96'h0);
        step(IDLE_W, K0, 1'b0);
        check("t5_count_after_clr", 96'(word_err_cnt), 96'd1);
        send_idle(FRAME_LEN);

        // Asynchronous reset in the middle of a payload.
        step(SOF_W, K0, 1'b0);
        for (int k = 0; k < 3; k++) step(32'(k), DC, 1'b0);
        #2 rst = 1'b1;
        #1 check("t6_async_reset", dut_vec(), 96'h0);
        model_reset();
        repeat (2) @(negedge rx_clk);
        rst = 1'b0;
        send_frame(-1, 32'h0);
        check("t6_frame_ok", 96'(frame_ok), 96'd1);
        check("t6_frame_cnt", 96'(frame_cnt), 96'd1);
        send_idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
